// File: rtl/nf_ram_arb.sv
// rtl/nf_ram_arb.sv - two-requester round-robin arbiter/sequencer for the single-port nf_ram
module nf_ram_arb #(
    parameter int depth = 64
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic        m0_we,
    input  logic [31:0] m0_wd,
    output logic [31:0] m0_rd,
    output logic        m0_ack,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic        m1_we,
    input  logic [31:0] m1_wd,
    output logic [31:0] m1_rd,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] ram_addr,
    output logic        ram_we,
    output logic [31:0] ram_wd,
    input  logic [31:0] ram_rd
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [29:0] depth_w = 30'(depth);

    state_t      state, state_nxt;
    logic [29:0] addr_q;
    logic [31:0] wd_q;
    logic        we_q, err_q, grant_q, last_grant;

    logic        elig0, elig1, win_valid, winner;
    logic [29:0] sel_addr;
    logic [31:0] sel_wd;
    logic        sel_we;

    // Byte-offset bits carry no meaning for a word-wide RAM.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{m0_addr[1:0], m1_addr[1:0]};

    // The requester acked this cycle is blind-spotted: its req is still the old one.
    always_comb begin
        elig0     = m0_req & ~((state == RESP) & ~grant_q);
        elig1     = m1_req & ~((state == RESP) &  grant_q);
        win_valid = elig0 | elig1;
        winner    = (elig0 & elig1) ? ~last_grant : elig1;
        sel_addr  = winner ? m1_addr[31:2] : m0_addr[31:2];
        sel_wd    = winner ? m1_wd : m0_wd;
        sel_we    = winner ? m1_we : m0_we;

        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = win_valid ? ACCESS : IDLE;
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = win_valid ? ACCESS : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant_q    <= 1'b0;
            addr_q     <= '0;
            wd_q       <= '0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            m0_ack     <= 1'b0;
            m1_ack     <= 1'b0;
            m0_err     <= 1'b0;
            m1_err     <= 1'b0;
            m0_rd      <= '0;
            m1_rd      <= '0;
        end else begin
            state  <= state_nxt;
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            m0_err <= 1'b0;
            m1_err <= 1'b0;

            if ((state == IDLE || state == RESP) && win_valid) begin
                addr_q     <= sel_addr;
                wd_q       <= sel_wd;
                we_q       <= sel_we;
                err_q      <= (sel_addr >= depth_w);
                grant_q    <= winner;
                last_grant <= winner;
            end

            if (state == ACCESS) begin
                if (grant_q) begin
                    m1_ack <= 1'b1;
                    m1_err <= err_q;
                    if (!we_q) m1_rd <= err_q ? 32'h0 : ram_rd;
                end else begin
                    m0_ack <= 1'b1;
                    m0_err <= err_q;
                    if (!we_q) m0_rd <= err_q ? 32'h0 : ram_rd;
                end
            end
        end
    end

    // resetn gating kills a write whose ACCESS cycle coincides with reset.
    assign ram_addr = {2'b00, addr_q};
    assign ram_wd   = wd_q;
    assign ram_we   = (state == ACCESS) & we_q & ~err_q & resetn;

endmodule

// File: tb/tb_nf_ram_arb.sv
// tb/tb_nf_ram_arb.sv - directed self-checking bench for nf_ram_arb with a behavioural RAM
module tb_nf_ram_arb;

    logic        clk = 1'b0;
    logic        resetn;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wd, m1_addr, m1_wd;
    logic [31:0] m0_rd, m1_rd;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] ram_addr, ram_wd, ram_rd;
    logic        ram_we;

    logic [31:0] mem [0:63];
    int          we_cnt = 0;
    int          errors = 0;
    int          checks = 0;
    int          we_base;

    always #5 clk = ~clk;

    nf_ram_arb #(.depth(64)) dut (
        .clk(clk), .resetn(resetn),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_wd(m0_wd),
        .m0_rd(m0_rd), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wd(m1_wd),
        .m1_rd(m1_rd), .m1_ack(m1_ack), .m1_err(m1_err),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wd(ram_wd), .ram_rd(ram_rd)
    );

    assign ram_rd = mem[ram_addr[5:0]];

    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr[5:0]] <= ram_wd;
            we_cnt = we_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[0] = 32'hA5A50000;
        mem[3] = 32'h33330003;
        mem[5] = 32'hCAFE0005;
        mem[6] = 32'h11110006;
        resetn = 1'b0;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wd = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wd = '0;
        step(); step();
        check("rst_m0_ack", {31'b0, m0_ack}, 32'h0);
        check("rst_m1_ack", {31'b0, m1_ack}, 32'h0);
        check("rst_m0_rd", m0_rd, 32'h0);
        check("rst_m1_rd", m1_rd, 32'h0);
        check("rst_ram_addr", ram_addr, 32'h0);
        check("rst_ram_wd", ram_wd, 32'h0);
        check("rst_ram_we", {31'b0, ram_we}, 32'h0);
        resetn = 1'b1;
        step();

        // contention from reset: m0 first, then m1
        m0_req = 1'b1; m0_addr = 32'h14;
        m1_req = 1'b1; m1_addr = 32'h18;
        step();
        check("cont_access_m0_ack", {31'b0, m0_ack}, 32'h0);
        check("cont_access_addr", ram_addr, 32'h5);
        step();
        check("cont_m0_ack", {31'b0, m0_ack}, 32'h1);
        check("cont_m1_ack_early", {31'b0, m1_ack}, 32'h0);
        check("cont_m0_rd", m0_rd, 32'hCAFE0005);
        m0_req = 1'b0;
        step();
        check("cont_m0_ack_pulse", {31'b0, m0_ack}, 32'h0);
        step();
        check("cont_m1_ack", {31'b0, m1_ack}, 32'h1);
        check("cont_m1_rd", m1_rd, 32'h11110006);
        check("cont_m0_rd_hold", m0_rd, 32'hCAFE0005);
        m1_req = 1'b0;
        step();
        check("cont_m1_ack_pulse", {31'b0, m1_ack}, 32'h0);

        // single m0 read, latency two cycles
        m0_req = 1'b1; m0_addr = 32'h17;
        step();
        check("rd_lat1_ack", {31'b0, m0_ack}, 32'h0);
        step();
        check("rd_ack", {31'b0, m0_ack}, 32'h1);
        check("rd_err", {31'b0, m0_err}, 32'h0);
        check("rd_data", m0_rd, 32'hCAFE0005);
        m0_req = 1'b0;
        step();

        // last grant was m0: continuous contention alternates m1,m0,m1,m0
        m0_req = 1'b1; m0_addr = 32'h0C;
        m1_req = 1'b1; m1_addr = 32'h14;
        for (int k = 0; k < 4; k++) begin
            step();
            check("alt_gap_m0", {31'b0, m0_ack}, 32'h0);
            check("alt_gap_m1", {31'b0, m1_ack}, 32'h0);
            step();
            check("alt_m0_ack", {31'b0, m0_ack}, (k % 2 == 1) ? 32'h1 : 32'h0);
            check("alt_m1_ack", {31'b0, m1_ack}, (k % 2 == 0) ? 32'h1 : 32'h0);
        end
        check("alt_m0_rd", m0_rd, 32'h33330003);
        check("alt_m1_rd", m1_rd, 32'hCAFE0005);
        m0_req = 1'b0; m1_req = 1'b0;
        step();
        step();
        check("alt_idle_m0", {31'b0, m0_ack}, 32'h0);
        check("alt_idle_m1", {31'b0, m1_ack}, 32'h0);

        // m1 write then read back
        we_base = we_cnt;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h08; m1_wd = 32'hDEADBEEF;
        step();
        check("wr_ram_we", {31'b0, ram_we}, 32'h1);
        check("wr_ram_addr", ram_addr, 32'h2);
        check("wr_ram_wd", ram_wd, 32'hDEADBEEF);
        step();
        check("wr_ack", {31'b0, m1_ack}, 32'h1);
        check("wr_err", {31'b0, m1_err}, 32'h0);
        check("wr_rd_unchanged", m1_rd, 32'hCAFE0005);
        check("wr_ram_we_off", {31'b0, ram_we}, 32'h0);
        m1_req = 1'b0; m1_we = 1'b0;
        step();
        check("wr_once", we_cnt - we_base, 32'h1);
        check("wr_mem", mem[2], 32'hDEADBEEF);
        m1_req = 1'b1;
        step(); step();
        check("wrrd_ack", {31'b0, m1_ack}, 32'h1);
        check("wrrd_data", m1_rd, 32'hDEADBEEF);
        m1_req = 1'b0;
        step();

        // out-of-range write and read
        we_base = we_cnt;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h100; m0_wd = 32'h12345678;
        step();
        check("oor_wr_ram_we", {31'b0, ram_we}, 32'h0);
        step();
        check("oor_wr_ack", {31'b0, m0_ack}, 32'h1);
        check("oor_wr_err", {31'b0, m0_err}, 32'h1);
        check("oor_wr_rd_hold", m0_rd, 32'h33330003);
        m0_req = 1'b0; m0_we = 1'b0;
        step();
        check("oor_wr_none", we_cnt - we_base, 32'h0);
        check("oor_mem0", mem[0], 32'hA5A50000);
        check("oor_err_pulse", {31'b0, m0_err}, 32'h0);
        m0_req = 1'b1;
        step(); step();
        check("oor_rd_ack", {31'b0, m0_ack}, 32'h1);
        check("oor_rd_err", {31'b0, m0_err}, 32'h1);
        check("oor_rd_data", m0_rd, 32'h0);
        m0_req = 1'b0;
        step();

        // reset during a write's ACCESS cycle
        we_base = we_cnt;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h0C; m0_wd = 32'hBADBAD00;
        step();
        resetn = 1'b0;
        #1;
        check("rstacc_we_gated", {31'b0, ram_we}, 32'h0);
        step();
        check("rstacc_m0_ack", {31'b0, m0_ack}, 32'h0);
        check("rstacc_m0_err", {31'b0, m0_err}, 32'h0);
        check("rstacc_ram_addr", ram_addr, 32'h0);
        check("rstacc_ram_wd", ram_wd, 32'h0);
        check("rstacc_mem", mem[3], 32'h33330003);
        check("rstacc_no_write", we_cnt - we_base, 32'h0);
        resetn = 1'b1;
        m0_req = 1'b0; m0_we = 1'b0;
        step();
        check("rstacc_after_ack", {31'b0, m0_ack}, 32'h0);
        m0_req = 1'b1; m0_addr = 32'h18;
        step();
        check("post_rst_lat", {31'b0, m0_ack}, 32'h0);
        step();
        check("post_rst_ack", {31'b0, m0_ack}, 32'h1);
        check("post_rst_rd", m0_rd, 32'h11110006);
        m0_req = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
